// File: rtl/cpu_io_timer_pkg.sv
// ----------------------------------------------------------------------------
// cpu_io_timer_pkg
//   Shared definitions for the memory-mapped I/O port / interval timer block.
//   Register offsets within the 4-byte window and TCTL/PORT bit positions.
//   Also used by the block RAM decode to suppress memory writes on a hit.
// ----------------------------------------------------------------------------
package cpu_io_timer_pkg;

  // Register offsets, selected by address_next[1:0]
  typedef enum logic [1:0] {
    IO_PORT = 2'd0,
    IO_TCTL = 2'd1,
    IO_TLO  = 2'd2,
    IO_THI  = 2'd3
  } io_off_e;

  // TCTL bit indices
  localparam int TCTL_EN      = 0;
  localparam int TCTL_IE      = 1;
  localparam int TCTL_NMISEL  = 2;
  localparam int TCTL_ONESHOT = 3;
  localparam int TCTL_EXP     = 7;

  // PORT bit indices
  localparam int PORT_SOFT_IRQ = 0;
  localparam int PORT_SOFT_NMI = 1;

  // Window hit: the low two address bits select the register, the rest must
  // match the base address.
  function automatic logic io_hit(input logic [15:0] addr, input logic [15:0] base);
    return addr[15:2] == base[15:2];
  endfunction

endpackage

// File: rtl/cpu_io_timer_io_interval_timer.sv
// ----------------------------------------------------------------------------
// io_interval_timer
//   Prescaler, 16-bit down counter, expired flag and reload/one-shot logic.
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   i_en        in   timer enable (TCTL.EN)
//   i_oneshot   in   one-shot mode (TCTL.ONESHOT)
//   i_reload    in   16-bit reload value {THI, TLO}
//   i_load      in   THI write strobe: load counter, clear EXP
//   i_load_val  in   value loaded into the counter on i_load
//   i_exp_clr   in   TCTL write with EXP bit set
//   o_exp       out  expired flag
//   o_stop      out  one-shot expiry this cycle: top clears EN
// ----------------------------------------------------------------------------
module io_interval_timer #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_en,
  input  logic        i_oneshot,
  input  logic [15:0] i_reload,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_exp_clr,
  output logic        o_exp,
  output logic        o_stop
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic [15:0]   r_cnt;
  logic          r_exp;
  logic          w_tick;
  logic          w_expire;

  assign w_tick   = i_en && (r_pre == PRE_LAST);
  assign w_expire = w_tick && (r_cnt == 16'd0);
  assign o_stop   = w_expire && i_oneshot;
  assign o_exp    = r_exp;

  // Prescaler is parked at 0 while disabled so that enabling always gives a
  // full prescale period before the first tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (!i_en || (r_pre == PRE_LAST)) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // A THI write has priority over a tick landing in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 16'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (w_tick) begin
      if (r_cnt != 16'd0) begin
        r_cnt <= r_cnt - 16'd1;
      end else if (!i_oneshot) begin
        r_cnt <= i_reload;
      end
    end
  end

  // Expiry beats a software clear in the same cycle; a THI write beats both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exp <= 1'b0;
    end else if (i_load) begin
      r_exp <= 1'b0;
    end else if (w_expire) begin
      r_exp <= 1'b1;
    end else if (i_exp_clr) begin
      r_exp <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_io_timer.sv
// ----------------------------------------------------------------------------
// cpu_io_timer
//   Memory-mapped I/O port plus 16-bit interval timer on the CPU data bus.
//   Decodes the CPU's next-cycle address/write like the block RAM does and
//   returns read data one cycle later; drives the CPU irq/nmi inputs.
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   ready         in   bus ready; no write or read-data update when low
//   address_next  in   CPU next-cycle address
//   write_next    in   CPU next-cycle write strobe
//   data_in       in   CPU write data
//   rd_data       out  registered read data (cycle after the address)
//   cs            out  registered: rd_data belongs to this block
//   irq           out  registered level interrupt request
//   nmi           out  registered level NMI request
// ----------------------------------------------------------------------------
module cpu_io_timer
  import cpu_io_timer_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'hBFFC,
  parameter int          PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ready,
  input  logic [15:0] address_next,
  input  logic        write_next,
  input  logic [7:0]  data_in,
  output logic [7:0]  rd_data,
  output logic        cs,
  output logic        irq,
  output logic        nmi
);

  logic [7:0] r_port;
  logic       r_en;
  logic       r_ie;
  logic       r_nmisel;
  logic       r_oneshot;
  logic [7:0] r_tlo;
  logic [7:0] r_thi;
  logic [7:0] r_rd_data;
  logic       r_cs;
  logic       r_irq;
  logic       r_nmi;

  logic       w_hit;
  io_off_e    w_off;
  logic       w_wr;
  logic       w_wr_port;
  logic       w_wr_tctl;
  logic       w_wr_tlo;
  logic       w_wr_thi;
  logic       w_exp;
  logic       w_stop;
  logic [7:0] w_tctl;
  logic [7:0] w_rd_mux;

  assign w_hit     = io_hit(address_next, BASE);
  assign w_off     = io_off_e'(address_next[1:0]);
  assign w_wr      = w_hit && write_next && ready;
  assign w_wr_port = w_wr && (w_off == IO_PORT);
  assign w_wr_tctl = w_wr && (w_off == IO_TCTL);
  assign w_wr_tlo  = w_wr && (w_off == IO_TLO);
  assign w_wr_thi  = w_wr && (w_off == IO_THI);

  // Bits [6:4] are unimplemented and read as zero.
  assign w_tctl = {w_exp, 3'b000, r_oneshot, r_nmisel, r_ie, r_en};

  always_comb begin
    w_rd_mux = r_port;
    case (w_off)
      IO_PORT: w_rd_mux = r_port;
      IO_TCTL: w_rd_mux = w_tctl;
      IO_TLO:  w_rd_mux = r_tlo;
      default: w_rd_mux = r_thi;
    endcase
  end

  io_interval_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (r_en),
    .i_oneshot  (r_oneshot),
    .i_reload   ({r_thi, r_tlo}),
    .i_load     (w_wr_thi),
    .i_load_val ({data_in, r_tlo}),
    .i_exp_clr  (w_wr_tctl && data_in[TCTL_EXP]),
    .o_exp      (w_exp),
    .o_stop     (w_stop)
  );

  // Control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_port    <= 8'h00;
      r_en      <= 1'b0;
      r_ie      <= 1'b0;
      r_nmisel  <= 1'b0;
      r_oneshot <= 1'b0;
      r_tlo     <= 8'h00;
      r_thi     <= 8'h00;
    end else begin
      if (w_wr_port) r_port <= data_in;
      if (w_wr_tlo)  r_tlo  <= data_in;
      if (w_wr_thi)  r_thi  <= data_in;
      if (w_wr_tctl) begin
        r_ie      <= data_in[TCTL_IE];
        r_nmisel  <= data_in[TCTL_NMISEL];
        r_oneshot <= data_in[TCTL_ONESHOT];
      end
      // Software write of EN wins over the one-shot auto-clear.
      if (w_wr_tctl) begin
        r_en <= data_in[TCTL_EN];
      end else if (w_stop) begin
        r_en <= 1'b0;
      end
    end
  end

  // Read path: rd_data follows the decoded register whenever the bus is ready,
  // regardless of hit; cs tells the board mux whether to use it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data <= 8'h00;
      r_cs      <= 1'b0;
    end else if (ready) begin
      r_rd_data <= w_rd_mux;
      r_cs      <= w_hit && !write_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq <= 1'b0;
      r_nmi <= 1'b0;
    end else begin
      r_irq <= r_port[PORT_SOFT_IRQ] | (w_exp & r_ie & ~r_nmisel);
      r_nmi <= r_port[PORT_SOFT_NMI] | (w_exp & r_ie &  r_nmisel);
    end
  end

  assign rd_data = r_rd_data;
  assign cs      = r_cs;
  assign irq     = r_irq;
  assign nmi     = r_nmi;

endmodule
